// File: rtl/pipe_ctrl_pkg.sv
// +------------------------------------------------------------------------+
// | Module   : pipe_ctrl_pkg                                                |
// | Brief    : Opcodes, instruction field slices and FSM encoding shared   |
// |            by the pipeline hazard controller.                          |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Only these formats read rt; for loads and immediates rt is a destination.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// +------------------------------------------------------------------------+
// | Module   : hazard_detect                                                |
// | Brief    : Combinational load-use hazard equation for IF/ID vs ID/EX.  |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic        i_mem_read,
    input  logic [4:0]  i_ex_rt,
    output logic        o_hazard
);

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_unused_imm;

    assign w_op         = i_instr[OP_MSB:OP_LSB];
    assign w_rs         = i_instr[RS_MSB:RS_LSB];
    assign w_rt         = i_instr[RT_MSB:RT_LSB];
    assign w_unused_imm = ^i_instr[15:0];

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign o_hazard = i_mem_read && (i_ex_rt != 5'd0) &&
                      ((i_ex_rt == w_rs) || (uses_rt(w_op) && (i_ex_rt == w_rt)));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// +------------------------------------------------------------------------+
// | Module   : pipeline_hazard_ctrl                                         |
// | Brief    : Load-use stall / taken-branch flush sequencer for IF-ID-EX. |
// |            HAZARD_PERF_CNT_EN adds saturating stall/flush counters.    |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_id_instr,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic             mem_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             stall_active
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [2:0] c_rem_init = 3'(LOAD_STALL_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_rem;
    logic [2:0] w_next_rem;
    logic       w_hazard;
    logic       w_branch_flush;

    hazard_detect u_hazard_detect (
        .i_instr    (if_id_instr),
        .i_mem_read (id_ex_mem_read),
        .i_ex_rt    (id_ex_rt),
        .o_hazard   (w_hazard)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_rem   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_rem     = r_rem;
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        id_ex_bubble   = 1'b0;
        w_branch_flush = 1'b0;
        stall_active   = (r_state == ST_STALL);

        // A taken branch wins in either state and squashes any stalled instruction.
        if (mem_branch_taken) begin
            w_branch_flush = 1'b1;
            w_next_state   = ST_RUN;
            w_next_rem     = 3'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hazard) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            w_next_state = ST_STALL;
                            w_next_rem   = c_rem_init;
                        end
                    end
                end
                ST_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    w_next_rem   = r_rem - 3'd1;
                    if (r_rem == 3'd1) begin
                        w_next_state = ST_RUN;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_rem   = 3'd0;
                end
            endcase
        end

        // Reset freezes the front end and keeps ID/EX drained.
        if (!rst) begin
            pc_write       = 1'b0;
            if_id_write    = 1'b0;
            id_ex_bubble   = 1'b1;
            w_branch_flush = 1'b0;
        end
    end

    assign if_id_flush  = w_branch_flush;
    assign id_ex_flush  = w_branch_flush;
    assign ex_mem_flush = w_branch_flush;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (id_ex_bubble && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_one;
            end
            if (w_branch_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_one;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// +------------------------------------------------------------------------+
// | Module   : tb_pipeline_hazard_ctrl                                      |
// | Brief    : Directed + random check of two controller instances         |
// |            (1-cycle and 3-cycle load stalls) against a cycle model.    |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic        clk;
    logic        rst;
    logic [31:0] if_id_instr;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic        mem_branch_taken;

    logic [6:0]  w_outs [2];
    logic [CNT_W-1:0] w_scnt [2];
    logic [CNT_W-1:0] w_fcnt [2];

    int n_chk;
    int n_pass;
    int cyc;

    // Model state: bubbles still owed after the current cycle, and event counts.
    int sl [2];
    int sc [2];
    int fc [2];
    int lsc [2];

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(CNT_W)) u_dut1 (
        .clk              (clk),
        .rst              (rst),
        .if_id_instr      (if_id_instr),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_rt         (id_ex_rt),
        .mem_branch_taken (mem_branch_taken),
        .pc_write         (w_outs[0][6]),
        .if_id_write      (w_outs[0][5]),
        .id_ex_bubble     (w_outs[0][4]),
        .if_id_flush      (w_outs[0][3]),
        .id_ex_flush      (w_outs[0][2]),
        .ex_mem_flush     (w_outs[0][1]),
        .stall_active     (w_outs[0][0])
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt        (w_scnt[0]),
        .flush_cnt        (w_fcnt[0])
`endif
    );

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(CNT_W)) u_dut3 (
        .clk              (clk),
        .rst              (rst),
        .if_id_instr      (if_id_instr),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_rt         (id_ex_rt),
        .mem_branch_taken (mem_branch_taken),
        .pc_write         (w_outs[1][6]),
        .if_id_write      (w_outs[1][5]),
        .id_ex_bubble     (w_outs[1][4]),
        .if_id_flush      (w_outs[1][3]),
        .id_ex_flush      (w_outs[1][2]),
        .ex_mem_flush     (w_outs[1][1]),
        .stall_active     (w_outs[1][0])
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt        (w_scnt[1]),
        .flush_cnt        (w_fcnt[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int imm);
        logic [5:0]  o;
        logic [4:0]  s;
        logic [4:0]  t;
        logic [15:0] i;
        o = 6'(op);
        s = 5'(rs);
        t = 5'(rt);
        i = 16'(imm);
        return {o, s, t, i};
    endfunction

    function automatic bit ref_hazard(input logic [31:0] instr, input logic mr, input logic [4:0] ldst);
        int op;
        int rs;
        int rt;
        bit reads_rt;
        op = int'(instr >> 26);
        rs = int'((instr >> 21) & 32'h1f);
        rt = int'((instr >> 16) & 32'h1f);
        reads_rt = (op == 0) || (op == 43) || (op == 4);
        return mr && (ldst != 0) && ((int'(ldst) == rs) || (reads_rt && int'(ldst) == rt));
    endfunction

    // One clock: drive at negedge, check Mealy outputs, advance the model.
    task automatic cycle(input logic r, input logic [31:0] instr, input logic mr,
                         input logic [4:0] ldst, input logic br);
        logic [6:0] exp;
        bit         hz;
        @(negedge clk);
        rst              = r;
        if_id_instr      = instr;
        id_ex_mem_read   = mr;
        id_ex_rt         = ldst;
        mem_branch_taken = br;
        #1;
        hz = ref_hazard(instr, mr, ldst);
        for (int d = 0; d < 2; d++) begin
            if (!r) begin
                sl[d] = 0;
                sc[d] = 0;
                fc[d] = 0;
                exp = 7'b0010000;
            end else if (br) begin
                exp = {6'b110111, sl[d] > 0};
            end else if (sl[d] > 0) begin
                exp = 7'b0010001;
            end else if (hz) begin
                exp = 7'b0010000;
            end else begin
                exp = 7'b1100000;
            end
            check(d == 0 ? "outs_lsc1" : "outs_lsc3", 32'(w_outs[d]), 32'(exp));
`ifdef HAZARD_PERF_CNT_EN
            check(d == 0 ? "stall_cnt_lsc1" : "stall_cnt_lsc3", 32'(w_scnt[d]), 32'(sc[d]));
            check(d == 0 ? "flush_cnt_lsc1" : "flush_cnt_lsc3", 32'(w_fcnt[d]), 32'(fc[d]));
`endif
            if (r) begin
                if (exp[4] && sc[d] < CNT_MAX) sc[d]++;
                if (br && fc[d] < CNT_MAX) fc[d]++;
                if (br) sl[d] = 0;
                else if (sl[d] > 0) sl[d]--;
                else if (hz) sl[d] = lsc[d] - 1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    logic [31:0] add_r5_r4_r2;
    logic [31:0] rnd_instr;
    int          ops [5];

    initial begin
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        lsc[0] = 1;
        lsc[1] = 3;
        for (int d = 0; d < 2; d++) begin
            sl[d] = 0;
            sc[d] = 0;
            fc[d] = 0;
        end
        rst = 1'b0;
        if_id_instr = 32'h0;
        id_ex_mem_read = 1'b0;
        id_ex_rt = 5'd0;
        mem_branch_taken = 1'b0;
        ops = '{0, 35, 43, 4, 8};
        add_r5_r4_r2 = {6'd0, 5'd4, 5'd2, 5'd5, 5'd0, 6'h20};

        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        idle(2);

        // Load-use on rs, then the bubble clears mem_read.
        cycle(1'b1, add_r5_r4_r2, 1'b1, 5'd4, 1'b0);
        cycle(1'b1, add_r5_r4_r2, 1'b0, 5'd4, 1'b0);
        idle(3);

        // No false hazards: load to r0, and LW whose rt is a destination.
        cycle(1'b1, mk(0, 0, 3, 0), 1'b1, 5'd0, 1'b0);
        cycle(1'b1, mk(35, 1, 4, 0), 1'b1, 5'd4, 1'b0);
        idle(1);
        // SW reads rt as store data.
        cycle(1'b1, mk(43, 1, 4, 16), 1'b1, 5'd4, 1'b0);
        idle(3);

        // Branch beats a simultaneous hazard; then abort a stall in its 2nd cycle.
        cycle(1'b1, add_r5_r4_r2, 1'b1, 5'd4, 1'b1);
        cycle(1'b1, add_r5_r4_r2, 1'b1, 5'd4, 1'b0);
        cycle(1'b1, add_r5_r4_r2, 1'b0, 5'd4, 1'b1);
        idle(2);

        // Back-to-back hazards and asynchronous reset in mid-stall.
        cycle(1'b1, mk(4, 7, 4, 2), 1'b1, 5'd4, 1'b0);
        idle(2);
        cycle(1'b1, mk(4, 7, 4, 2), 1'b1, 5'd4, 1'b0);
        idle(1);
        cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        idle(2);

        // Counter saturation and flush counting.
        cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, add_r5_r4_r2, 1'b1, 5'd4, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 5'd0, 1'b1);
        cycle(1'b1, 32'h0, 1'b0, 5'd0, 1'b1);
        idle(1);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt_sat", 32'(w_scnt[0]), 32'd15);
        check("flush_cnt_two", 32'(w_fcnt[1]), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("stall_cnt_rst", 32'(w_scnt[1]), 32'd0);
        check("flush_cnt_rst", 32'(w_fcnt[0]), 32'd0);
`endif
        cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            rnd_instr = mk(ops[$urandom_range(0, 4)], $urandom_range(0, 7),
                           $urandom_range(0, 7), $urandom_range(0, 65535));
            cycle(($urandom_range(0, 63) != 0), rnd_instr, ($urandom_range(0, 2) != 0),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
